// File: rtl/attn_out_collector_if.sv
// Readback stream between attn_out_collector and its downstream consumer.
//   m_valid : beat valid (collector -> consumer)
//   m_ready : consumer ready (consumer -> collector)
//   m_data  : 128-bit beat payload (four fp32 lanes)
//   m_addr  : output-SRAM address the beat was read from
//   m_last  : final beat of the drain
interface attn_out_collector_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 7;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_addr, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_addr, input m_last, output m_ready);
endinterface

// File: rtl/attn_out_collector.sv
// Collects (row, group, data) beats from the attention top into the 128x128
// output SRAM, tracks which entries were written, and after the run drains the
// written entries in ascending address order over a valid/ready stream.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_row/in_group/in_data/in_done : output beat stream + end-of-run pulse
//   O_mem_wr_en/wr_addr/wr_data    : SRAM write port (registered)
//   O_mem_rd_en/rd_addr, O_mem_out : SRAM read port, data READ_LAT cycles after read
//   drain_start                    : begins readback from S_READY
//   m_if (master)                  : readback stream m_valid/m_ready/m_data/m_addr/m_last
//   wr_count, dup_err, proto_err   : distinct entries written, sticky error flags
//   busy, done                     : not-idle status, end-of-drain pulse
module attn_out_collector #(
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = READ_LAT + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [1:0]             in_row,
  input  logic [4:0]             in_group,
  input  logic [127:0]           in_data,
  input  logic                   in_done,
  output logic                   O_mem_wr_en,
  output logic [6:0]             O_mem_wr_addr,
  output logic [127:0]           O_mem_wr_data,
  output logic                   O_mem_rd_en,
  output logic [6:0]             O_mem_rd_addr,
  input  logic [127:0]           O_mem_out,
  input  logic                   drain_start,
  attn_out_collector_if.master   m_if,
  output logic [7:0]             wr_count,
  output logic                   dup_err,
  output logic                   proto_err,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ENTRIES = 128;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_READY,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t              state, state_n;
  logic [ENTRIES-1:0]  written;
  logic [ADDR_W-1:0]   scan, scan_n;
  logic [CNT_W-1:0]    remaining, remaining_n;
  logic [ADDR_W-1:0]   in_addr;
  logic                wr_accept;
  logic                stray;
  logic                clear_all;
  logic                issue;
  logic                issue_last;
  logic                rd_last;
  tag_t                tag_q [READ_LAT];
  beat_t               fifo_q [FIFO_DEPTH];
  beat_t               fifo_n [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld, fifo_vld_n;
  logic [CNT_W-1:0]    fifo_cnt, fifo_cnt_n;
  logic [CNT_W-1:0]    inflight;
  logic                pop;
  logic                push;
  logic                credit;

  assign in_addr = {in_group, in_row};

  // FIFO head is entry 0 of a shifting buffer, so the stream outputs come straight from flops
  assign m_if.m_valid = fifo_vld[0];
  assign m_if.m_data  = fifo_q[0].data;
  assign m_if.m_addr  = fifo_q[0].addr;
  assign m_if.m_last  = fifo_q[0].last;

  assign pop  = fifo_vld[0] && m_if.m_ready;
  assign push = tag_q[READ_LAT-1].vld;

  // Reads not yet in the FIFO: the registered read strobe plus every tag stage
  always_comb begin
    inflight = CNT_W'(O_mem_rd_en);
    for (int i = 0; i < int'(READ_LAT); i++) begin
      inflight = inflight + CNT_W'(tag_q[i].vld);
    end
  end

  // A same-cycle pop frees a slot, which keeps a dense drain at one beat per cycle
  assign credit = (fifo_cnt + inflight) < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop));

  // Next-state and control
  always_comb begin
    state_n     = state;
    scan_n      = scan;
    remaining_n = remaining;
    wr_accept   = 1'b0;
    stray       = 1'b0;
    clear_all   = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        wr_accept = in_valid;
        if (in_done) begin
          state_n = S_READY;
        end else if (in_valid) begin
          state_n = S_COLLECT;
        end
      end
      S_READY: begin
        stray = in_valid;
        if (drain_start) begin
          if (wr_count == '0) begin
            state_n = S_DONE;
          end else begin
            remaining_n = wr_count;
            scan_n      = '0;
            state_n     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        stray = in_valid;
        if (remaining != '0) begin
          if (!written[scan]) begin
            scan_n = scan + ADDR_W'(1);
          end else if (credit) begin
            issue       = 1'b1;
            issue_last  = (remaining == CNT_W'(1));
            remaining_n = remaining - CNT_W'(1);
            scan_n      = scan + ADDR_W'(1);
          end
        end
        if (pop && fifo_q[0].last) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        stray     = in_valid;
        clear_all = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, scan pointer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scan      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      scan      <= scan_n;
      remaining <= remaining_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

  // SRAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_mem_wr_en   <= 1'b0;
      O_mem_wr_addr <= '0;
      O_mem_wr_data <= '0;
    end else begin
      O_mem_wr_en <= wr_accept;
      if (wr_accept) begin
        O_mem_wr_addr <= in_addr;
        O_mem_wr_data <= in_data;
      end
    end
  end

  // Written bitmap, distinct-entry count and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written   <= '0;
      wr_count  <= '0;
      dup_err   <= 1'b0;
      proto_err <= 1'b0;
    end else if (clear_all) begin
      written   <= '0;
      wr_count  <= '0;
      dup_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        written[in_addr] <= 1'b1;
        if (written[in_addr]) begin
          dup_err <= 1'b1;
        end else begin
          wr_count <= wr_count + CNT_W'(1);
        end
      end
      if (stray) begin
        proto_err <= 1'b1;
      end
    end
  end

  // SRAM read port and the tag pipeline that tracks read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_mem_rd_en   <= 1'b0;
      O_mem_rd_addr <= '0;
      rd_last       <= 1'b0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      O_mem_rd_en <= issue;
      if (issue) begin
        O_mem_rd_addr <= scan;
        rd_last       <= issue_last;
      end
      tag_q[0] <= '{vld: O_mem_rd_en, last: rd_last, addr: O_mem_rd_addr};
      for (int i = 1; i < int'(READ_LAT); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Skid FIFO next state: shift on pop, then append at the first free slot
  always_comb begin
    fifo_n     = fifo_q;
    fifo_vld_n = fifo_vld;
    fifo_cnt_n = fifo_cnt;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        fifo_n[i]     = fifo_q[i+1];
        fifo_vld_n[i] = fifo_vld[i+1];
      end
      fifo_vld_n[FIFO_DEPTH-1] = 1'b0;
      fifo_cnt_n = fifo_cnt - CNT_W'(1);
    end
    if (push) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (CNT_W'(i) == fifo_cnt_n) begin
          fifo_n[i]     = '{last: tag_q[READ_LAT-1].last, addr: tag_q[READ_LAT-1].addr, data: O_mem_out};
          fifo_vld_n[i] = 1'b1;
        end
      end
      fifo_cnt_n = fifo_cnt_n + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      fifo_vld <= '0;
      fifo_cnt <= '0;
    end else begin
      fifo_q   <= fifo_n;
      fifo_vld <= fifo_vld_n;
      fifo_cnt <= fifo_cnt_n;
    end
  end

endmodule
